// File: rtl/hazard_scoreboard_if.sv
// Pipeline <-> hazard scoreboard bundle: D-stage tag, branch/memory status in,
// stall/flush/forward controls and stall-cycle count out.
interface hazard_scoreboard_if #(
  parameter int unsigned ADDRESSWIDTH = 4,
  parameter int unsigned CNTWIDTH     = 16
);
  logic                    validD;
  logic [ADDRESSWIDTH-1:0] reg1AddressD;
  logic [ADDRESSWIDTH-1:0] reg2AddressD;
  logic [ADDRESSWIDTH-1:0] regDestinationAddressD;
  logic                    writeEnableD;
  logic                    isLoadD;
  logic                    isStoreD;
  logic                    takeBranchE;
  logic                    memReadyM;

  logic                    stallF;
  logic                    stallD;
  logic                    stallE;
  logic                    stallM;
  logic                    flushD;
  logic                    flushE;
  logic [1:0]              data1ForwardSelectorE;
  logic [1:0]              data2ForwardSelectorE;
  logic [CNTWIDTH-1:0]     stallCount;

  modport master (
    output validD, reg1AddressD, reg2AddressD, regDestinationAddressD,
           writeEnableD, isLoadD, isStoreD, takeBranchE, memReadyM,
    input  stallF, stallD, stallE, stallM, flushD, flushE,
           data1ForwardSelectorE, data2ForwardSelectorE, stallCount
  );

  modport slave (
    input  validD, reg1AddressD, reg2AddressD, regDestinationAddressD,
           writeEnableD, isLoadD, isStoreD, takeBranchE, memReadyM,
    output stallF, stallD, stallE, stallM, flushD, flushE,
           data1ForwardSelectorE, data2ForwardSelectorE, stallCount
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard for the 5-stage pipeline: shadow E/M/WB tags drive forwarding,
// load-use/interlock stalls, branch flushes and memory-wait freezes.
// Optional macro HAZARD_R0_HARDWIRED_EN: register 0 never matches any slot.
module hazard_scoreboard #(
  parameter int unsigned ADDRESSWIDTH = 4,
  parameter int unsigned FORWARDING   = 1,
  parameter int unsigned CNTWIDTH     = 16
) (
  input logic                clock,
  input logic                reset,
  hazard_scoreboard_if.slave hz
);

  typedef struct packed {
    logic                    valid;
    logic [ADDRESSWIDTH-1:0] dest;
    logic                    we;
    logic                    load;
    logic                    store;
    logic [ADDRESSWIDTH-1:0] src1;
    logic [ADDRESSWIDTH-1:0] src2;
  } slot_t;

  slot_t               e_q, m_q, wb_q;
  slot_t               e_d, m_d, wb_d;
  slot_t               d_tag;
  logic [CNTWIDTH-1:0] cnt_q, cnt_d;

  logic       mem_wait;
  logic       branch;
  logic       d_hazard;
  logic       hazard_stall;
  logic [1:0] sel1, sel2;

  function automatic logic hit(input logic [ADDRESSWIDTH-1:0] src, input slot_t s);
`ifdef HAZARD_R0_HARDWIRED_EN
    return s.valid && s.we && (s.dest == src) && (src != '0);
`else
    return s.valid && s.we && (s.dest == src);
`endif
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [ADDRESSWIDTH-1:0] src);
    if (hit(src, m_q) && !m_q.load) return 2'b10;
    else if (hit(src, wb_q))        return 2'b01;
    else                            return 2'b00;
  endfunction

  always_comb begin
    d_tag.valid = hz.validD;
    d_tag.dest  = hz.regDestinationAddressD;
    d_tag.we    = hz.writeEnableD;
    d_tag.load  = hz.isLoadD;
    d_tag.store = hz.isStoreD;
    d_tag.src1  = hz.reg1AddressD;
    d_tag.src2  = hz.reg2AddressD;
  end

  always_comb begin
    mem_wait = m_q.valid && (m_q.load || m_q.store) && !hz.memReadyM;
    branch   = hz.takeBranchE && !mem_wait;
    d_hazard = 1'b0;
    sel1     = 2'b00;
    sel2     = 2'b00;
    if (FORWARDING != 0) begin
      d_hazard = hz.validD && e_q.load &&
                 (hit(hz.reg1AddressD, e_q) || hit(hz.reg2AddressD, e_q));
      if (e_q.valid) begin
        sel1 = fwd_sel(e_q.src1);
        sel2 = fwd_sel(e_q.src2);
      end
    end else begin
      // Without bypassing, D waits until the producer reaches WB (regfile write-through).
      d_hazard = hz.validD &&
                 (hit(hz.reg1AddressD, e_q) || hit(hz.reg2AddressD, e_q) ||
                  hit(hz.reg1AddressD, m_q) || hit(hz.reg2AddressD, m_q));
    end
    hazard_stall = d_hazard && !mem_wait && !hz.takeBranchE;
  end

  assign hz.stallF                = mem_wait || hazard_stall;
  assign hz.stallD                = mem_wait || hazard_stall;
  assign hz.stallE                = mem_wait;
  assign hz.stallM                = mem_wait;
  assign hz.flushD                = branch;
  assign hz.flushE                = branch || hazard_stall;
  assign hz.data1ForwardSelectorE = sel1;
  assign hz.data2ForwardSelectorE = sel2;
  assign hz.stallCount            = cnt_q;

  always_comb begin
    e_d  = e_q;
    m_d  = m_q;
    wb_d = '0;
    if (!mem_wait) begin
      wb_d = m_q;
      m_d  = e_q;
      e_d  = (branch || hazard_stall) ? '0 : d_tag;
    end
    cnt_d = cnt_q;
    if (hz.stallF && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      e_q   <= '0;
      m_q   <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      e_q   <= e_d;
      m_q   <= m_d;
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
    end
  end

  // Tag fields carried for completeness but not consulted in these stages.
  logic unused_fields;
  assign unused_fields = ^{e_q.store, m_q.src1, m_q.src2,
                           wb_q.load, wb_q.store, wb_q.src1, wb_q.src2};

endmodule
